// File: rtl/decode_issue_arbiter_pkg.sv
// Shared decode definitions: datapath widths and the per-instruction metadata bundle
// carried alongside each instruction into the decode unit.
package decode_issue_arbiter_pkg;

    localparam int addressWidth            = 64;
    localparam int instructionWidth        = 32;
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int instructionCounterWidth = 64;

    typedef struct packed {
        logic [addressWidth-1:0]            address;
        logic                               is64Bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [instructionCounterWidth-1:0] majId;
    } instrMeta_t;

endpackage

// File: rtl/decode_issue_arbiter_rr_arbiter.sv
// Round-robin grant: returns the first requester at or after ptr, wrapping around,
// plus a flag saying whether anyone was requesting at all.
module rr_arbiter #(
    parameter int numReq   = 2,
    parameter int idxWidth = (numReq > 1) ? $clog2(numReq) : 1
) (
    input  logic [numReq-1:0]   req,
    input  logic [idxWidth-1:0] ptr,
    output logic [idxWidth-1:0] grant,
    output logic                anyGrant
);

    int idx;

    always_comb begin
        grant    = '0;
        anyGrant = 1'b0;
        idx      = 0;
        for (int i = 0; i < numReq; i++) begin
            idx = (int'(ptr) + i) % numReq;
            if (!anyGrant && req[idx]) begin
                grant    = idxWidth'(idx);
                anyGrant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_issue_arbiter.sv
// Shares one decode unit between several fetch threads: round-robin pick, stamp a
// monotonically increasing major ID, and hold the result in a one-entry output slot.
module decode_issue_arbiter
    import decode_issue_arbiter_pkg::*;
#(
    parameter int numThreads = 2,
    localparam int GrantWidth = (numThreads > 1) ? $clog2(numThreads) : 1
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic [numThreads-1:0]                  valid_i,
    output logic [numThreads-1:0]                  ready_o,
    input  logic [numThreads*instructionWidth-1:0] instruction_i,
    input  logic [numThreads*addressWidth-1:0]     address_i,
    input  logic [numThreads-1:0]                  is64Bit_i,
    input  logic [numThreads*PidSize-1:0]          pid_i,
    input  logic [numThreads*TidSize-1:0]          tid_i,
    input  logic                                   flush_i,
    input  logic                                   stall_i,
    output logic                                   enable_o,
    output logic [instructionWidth-1:0]            instruction_o,
    output logic [addressWidth-1:0]                address_o,
    output logic                                   is64Bit_o,
    output logic [PidSize-1:0]                     pid_o,
    output logic [TidSize-1:0]                     tid_o,
    output logic [instructionCounterWidth-1:0]     majId_o,
    output logic [GrantWidth-1:0]                  grantThread_o
);

    logic [GrantWidth-1:0]              rrPtr;
    logic [GrantWidth-1:0]              grantIdx;
    logic [GrantWidth-1:0]              nextPtr;
    logic                               anyGrant;
    logic                               canLoad;
    logic                               accept;
    logic                               consume;
    logic [instructionCounterWidth-1:0] idCounter;
    logic                               slotValid;
    logic [instructionWidth-1:0]        slotInstr;
    logic [GrantWidth-1:0]              slotThread;
    instrMeta_t                         slotMeta;
    instrMeta_t                         loadMeta;
    logic [instructionWidth-1:0]        loadInstr;

    rr_arbiter #(
        .numReq   (numThreads),
        .idxWidth (GrantWidth)
    ) rrArbiter (
        .req      (valid_i),
        .ptr      (rrPtr),
        .grant    (grantIdx),
        .anyGrant (anyGrant)
    );

    // An empty slot may load even under stall; flush always blocks loading.
    assign canLoad = !flush_i && (!slotValid || !stall_i);
    assign accept  = anyGrant && canLoad && reset_i;
    assign consume = slotValid && !stall_i;
    assign nextPtr = GrantWidth'((int'(grantIdx) + 1) % numThreads);

    always_comb begin
        ready_o = '0;
        if (accept) begin
            ready_o[grantIdx] = 1'b1;
        end
    end

    assign loadInstr        = instruction_i[int'(grantIdx)*instructionWidth +: instructionWidth];
    assign loadMeta.address = address_i[int'(grantIdx)*addressWidth +: addressWidth];
    assign loadMeta.is64Bit = is64Bit_i[grantIdx];
    assign loadMeta.pid     = pid_i[int'(grantIdx)*PidSize +: PidSize];
    assign loadMeta.tid     = tid_i[int'(grantIdx)*TidSize +: TidSize];
    assign loadMeta.majId   = idCounter;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            slotValid  <= 1'b0;
            slotInstr  <= '0;
            slotMeta   <= '0;
            slotThread <= '0;
            idCounter  <= '0;
            rrPtr      <= '0;
        end else if (flush_i) begin
            slotValid <= 1'b0;
        end else if (accept) begin
            slotValid  <= 1'b1;
            slotInstr  <= loadInstr;
            slotMeta   <= loadMeta;
            slotThread <= grantIdx;
            idCounter  <= idCounter + instructionCounterWidth'(1);
            rrPtr      <= nextPtr;
        end else if (consume) begin
            slotValid <= 1'b0;
        end
    end

    assign enable_o      = slotValid;
    assign instruction_o = slotInstr;
    assign address_o     = slotMeta.address;
    assign is64Bit_o     = slotMeta.is64Bit;
    assign pid_o         = slotMeta.pid;
    assign tid_o         = slotMeta.tid;
    assign majId_o       = slotMeta.majId;
    assign grantThread_o = slotThread;

endmodule

// File: tb/tb_decode_issue_arbiter.sv
// Directed self-checking bench for decode_issue_arbiter with two fetch threads.
module tb_decode_issue_arbiter;

    logic         clock_i;
    logic         reset_i;
    logic [1:0]   valid_i;
    logic [1:0]   ready_o;
    logic [63:0]  instruction_i;
    logic [127:0] address_i;
    logic [1:0]   is64Bit_i;
    logic [39:0]  pid_i;
    logic [31:0]  tid_i;
    logic         flush_i;
    logic         stall_i;
    logic         enable_o;
    logic [31:0]  instruction_o;
    logic [63:0]  address_o;
    logic         is64Bit_o;
    logic [19:0]  pid_o;
    logic [15:0]  tid_o;
    logic [63:0]  majId_o;
    logic [0:0]   grantThread_o;

    int compared;
    int mismatched;

    localparam logic [31:0] T0Instr = 32'h7C22_1A14;
    localparam logic [31:0] T1Instr = 32'h3C60_0001;

    decode_issue_arbiter #(.numThreads(2)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .instruction_i (instruction_i),
        .address_i     (address_i),
        .is64Bit_i     (is64Bit_i),
        .pid_i         (pid_i),
        .tid_i         (tid_i),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .enable_o      (enable_o),
        .instruction_o (instruction_o),
        .address_o     (address_o),
        .is64Bit_o     (is64Bit_o),
        .pid_o         (pid_o),
        .tid_o         (tid_o),
        .majId_o       (majId_o),
        .grantThread_o (grantThread_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic doReset();
        reset_i = 1'b0;
        #2;
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        valid_i = 2'b11;
        step();
        compared++; if (ready_o !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_ready got %b want 00", ready_o); end
        compared++; if (enable_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_enable got %b want 0", enable_o); end
        compared++; if (majId_o !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_majId got %h want 0", majId_o); end
        compared++; if (instruction_o !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_instr got %h want 0", instruction_o); end
        compared++; if (address_o !== 64'd0 || pid_o !== 20'd0 || tid_o !== 16'd0 || grantThread_o !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_fields got addr=%h pid=%h tid=%h g=%b want all 0", address_o, pid_o, tid_o, grantThread_o);
        end
        reset_i = 1'b1;
        valid_i = 2'b00;
    endtask

    task automatic test_single();
        doReset();
        valid_i = 2'b01;
        #1;
        compared++; if (ready_o !== 2'b01) begin mismatched++; $display("[TB] FAIL single_ready got %b want 01", ready_o); end
        step();
        valid_i = 2'b00;
        compared++; if (enable_o !== 1'b1) begin mismatched++; $display("[TB] FAIL single_enable got %b want 1", enable_o); end
        compared++; if (instruction_o !== T0Instr) begin mismatched++; $display("[TB] FAIL single_instr got %h want %h", instruction_o, T0Instr); end
        compared++; if (address_o !== 64'h100) begin mismatched++; $display("[TB] FAIL single_addr got %h want 100", address_o); end
        compared++; if (majId_o !== 64'd0 || grantThread_o !== 1'b0) begin mismatched++; $display("[TB] FAIL single_id got maj=%0d g=%0d want 0/0", majId_o, grantThread_o); end
        compared++; if (pid_o !== 20'h5 || tid_o !== 16'h1 || is64Bit_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL single_meta got pid=%h tid=%h m64=%b want 5/1/1", pid_o, tid_o, is64Bit_o);
        end
        step();
        compared++; if (enable_o !== 1'b0) begin mismatched++; $display("[TB] FAIL single_consume got %b want 0", enable_o); end
    endtask

    task automatic test_fairness();
        logic [1:0] expReady;
        doReset();
        valid_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            expReady = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            compared++; if (ready_o !== expReady) begin mismatched++; $display("[TB] FAIL fair_ready[%0d] got %b want %b", k, ready_o, expReady); end
            step();
            compared++; if (grantThread_o !== 1'(k % 2) || majId_o !== 64'(k) || enable_o !== 1'b1) begin
                mismatched++; $display("[TB] FAIL fair_grant[%0d] got g=%0d maj=%0d en=%b want g=%0d maj=%0d en=1", k, grantThread_o, majId_o, enable_o, k % 2, k);
            end
        end
        valid_i = 2'b00;
    endtask

    task automatic test_stall_hold();
        doReset();
        valid_i = 2'b11;
        repeat (4) step();
        compared++; if (majId_o !== 64'd3) begin mismatched++; $display("[TB] FAIL stall_setup got %0d want 3", majId_o); end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            compared++; if (ready_o !== 2'b00) begin mismatched++; $display("[TB] FAIL stall_ready[%0d] got %b want 00", k, ready_o); end
            step();
            compared++; if (majId_o !== 64'd3 || grantThread_o !== 1'b1 || enable_o !== 1'b1 || instruction_o !== T1Instr || is64Bit_o !== 1'b0) begin
                mismatched++; $display("[TB] FAIL stall_hold[%0d] got maj=%0d g=%0d en=%b instr=%h want 3/1/1/%h", k, majId_o, grantThread_o, enable_o, instruction_o, T1Instr);
            end
        end
        stall_i = 1'b0;
        #1;
        compared++; if (ready_o !== 2'b01) begin mismatched++; $display("[TB] FAIL stall_release_ready got %b want 01", ready_o); end
        step();
        compared++; if (majId_o !== 64'd4 || grantThread_o !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_release got maj=%0d g=%0d want 4/0", majId_o, grantThread_o); end
        valid_i = 2'b00;
    endtask

    task automatic test_flush();
        doReset();
        valid_i = 2'b11;
        repeat (8) step();
        compared++; if (majId_o !== 64'd7 || enable_o !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_setup got maj=%0d en=%b want 7/1", majId_o, enable_o); end
        flush_i = 1'b1;
        stall_i = 1'b1;
        #1;
        compared++; if (ready_o !== 2'b00) begin mismatched++; $display("[TB] FAIL flush_ready got %b want 00", ready_o); end
        step();
        compared++; if (enable_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_enable got %b want 0", enable_o); end
        flush_i = 1'b0;
        stall_i = 1'b0;
        #1;
        compared++; if (ready_o !== 2'b01) begin mismatched++; $display("[TB] FAIL flush_ptr got %b want 01", ready_o); end
        step();
        compared++; if (majId_o !== 64'd8 || grantThread_o !== 1'b0 || enable_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL flush_next got maj=%0d g=%0d en=%b want 8/0/1", majId_o, grantThread_o, enable_o);
        end
        valid_i = 2'b00;
        step();
    endtask

    task automatic test_counter_wrap();
        force dut.idCounter = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.idCounter;
        valid_i = 2'b11;
        #1;
        compared++; if (ready_o !== 2'b10) begin mismatched++; $display("[TB] FAIL wrap_ready got %b want 10", ready_o); end
        step();
        compared++; if (majId_o !== 64'hFFFF_FFFF_FFFF_FFFF || grantThread_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL wrap_max got maj=%h g=%0d want ffffffffffffffff/1", majId_o, grantThread_o);
        end
        step();
        compared++; if (majId_o !== 64'd0 || grantThread_o !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_zero got maj=%h g=%0d want 0/0", majId_o, grantThread_o); end
    endtask

    task automatic test_async_reset();
        stall_i = 1'b1;
        valid_i = 2'b11;
        #2;
        compared++; if (enable_o !== 1'b1 || instruction_o !== T0Instr) begin mismatched++; $display("[TB] FAIL areset_pre got en=%b instr=%h want 1/%h", enable_o, instruction_o, T0Instr); end
        reset_i = 1'b0;
        #1;
        compared++; if (enable_o !== 1'b0 || instruction_o !== 32'd0 || ready_o !== 2'b00) begin
            mismatched++; $display("[TB] FAIL areset_drop got en=%b instr=%h rdy=%b want 0/0/00", enable_o, instruction_o, ready_o);
        end
        #1;
        reset_i = 1'b1;
        stall_i = 1'b0;
        #1;
        compared++; if (ready_o !== 2'b01) begin mismatched++; $display("[TB] FAIL areset_prio got %b want 01", ready_o); end
        step();
        compared++; if (majId_o !== 64'd0 || grantThread_o !== 1'b0 || enable_o !== 1'b1) begin
            mismatched++; $display("[TB] FAIL areset_first got maj=%0d g=%0d en=%b want 0/0/1", majId_o, grantThread_o, enable_o);
        end
        valid_i = 2'b00;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset_i       = 1'b0;
        valid_i       = 2'b00;
        flush_i       = 1'b0;
        stall_i       = 1'b0;
        instruction_i = {T1Instr, T0Instr};
        address_i     = {64'h200, 64'h100};
        is64Bit_i     = 2'b01;
        pid_i         = {20'h6, 20'h5};
        tid_i         = {16'h2, 16'h1};

        test_reset();
        test_single();
        test_fairness();
        test_stall_hold();
        test_flush();
        test_counter_wrap();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
